// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin arbiter that shares one valid/ready target bus
// between N_REQ requesters. The winner's addr/data are captured at grant time
// and held on the target bus until the target accepts them.
//
// Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a transfer that
// waits longer than TIMEOUT cycles for m_ready is aborted and timeout_err pulses.
//
// Ports:
//   clk, rst_n      clock (posedge) and asynchronous active-low reset
//   req             per-requester level request
//   req_addr        packed addresses, requester i at [i*A_WIDTH +: A_WIDTH]
//   req_data        packed data, requester i at [i*D_WIDTH +: D_WIDTH]
//   grant           registered one-hot grant
//   done            one-cycle pulse when requester i's transfer completes
//   m_valid         target request valid
//   m_addr, m_data  target address/data, stable while m_valid
//   m_ready         target accept
//   busy            high while a transfer is in flight
//   timeout_err     one-cycle pulse on abort (constant 0 without ARB_TIMEOUT_EN)
module bus_rr_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*A_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*D_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           done,
  output logic                       m_valid,
  output logic [A_WIDTH-1:0]         m_addr,
  output logic [D_WIDTH-1:0]         m_data,
  input  logic                       m_ready,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Elaboration-time parameter sanity checks.
  if (N_REQ < 2) begin : g_bad_n_req
    $error("bus_rr_arbiter: N_REQ must be >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("bus_rr_arbiter: TIMEOUT must be >= 1");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_e;

  state_e               state_q,   state_d;
  logic [N_REQ-1:0]     grant_q,   grant_d;
  logic [N_REQ-1:0]     done_q,    done_d;
  logic                 m_valid_q, m_valid_d;
  logic [A_WIDTH-1:0]   m_addr_q,  m_addr_d;
  logic [D_WIDTH-1:0]   m_data_q,  m_data_d;
  logic                 busy_q,    busy_d;
  logic [PTR_W-1:0]     rr_ptr_q,  rr_ptr_d;
  logic [PTR_W-1:0]     idx_q,     idx_d;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0]     to_cnt_q,  to_cnt_d;
  logic                 timeout_err_q, timeout_err_d;
`endif

  // Unpacked views of the packed requester buses.
  logic [A_WIDTH-1:0] addr_arr [N_REQ];
  logic [D_WIDTH-1:0] data_arr [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*A_WIDTH +: A_WIDTH];
    assign data_arr[g] = req_data[g*D_WIDTH +: D_WIDTH];
  end

  // Rotating priority search starting at rr_ptr; wraps modulo N_REQ.
  logic             sel_found;
  logic [PTR_W-1:0] sel_idx;
  always_comb begin
    int unsigned cand;
    cand      = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!sel_found && req[PTR_W'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(cand);
      end
    end
  end

  // Pointer to the requester after the current owner, modulo N_REQ.
  logic [PTR_W-1:0] next_ptr;
  assign next_ptr = (idx_q == PTR_W'(N_REQ - 1)) ? '0 : idx_q + PTR_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = '0;
    m_valid_d = m_valid_q;
    m_addr_d  = m_addr_q;
    m_data_d  = m_data_q;
    busy_d    = busy_q;
    rr_ptr_d  = rr_ptr_q;
    idx_d     = idx_q;
`ifdef ARB_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d   = S_XFER;
          idx_d     = sel_idx;
          grant_d   = N_REQ'(1) << sel_idx;
          m_valid_d = 1'b1;
          busy_d    = 1'b1;
          m_addr_d  = addr_arr[sel_idx];
          m_data_d  = data_arr[sel_idx];
`ifdef ARB_TIMEOUT_EN
          to_cnt_d  = '0;
`endif
        end
      end
      S_XFER: begin
        if (m_ready) begin
          state_d   = S_IDLE;
          done_d    = N_REQ'(1) << idx_q;
          grant_d   = '0;
          m_valid_d = 1'b0;
          busy_d    = 1'b0;
          rr_ptr_d  = next_ptr;
        end
`ifdef ARB_TIMEOUT_EN
        // Abort once TIMEOUT stalled cycles have already been counted.
        else if (to_cnt_q == CNT_W'(TIMEOUT)) begin
          state_d       = S_IDLE;
          grant_d       = '0;
          m_valid_d     = 1'b0;
          busy_d        = 1'b0;
          rr_ptr_d      = next_ptr;
          timeout_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_data_q  <= '0;
      busy_q    <= 1'b0;
      rr_ptr_q  <= '0;
      idx_q     <= '0;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      m_valid_q <= m_valid_d;
      m_addr_q  <= m_addr_d;
      m_data_q  <= m_data_d;
      busy_q    <= busy_d;
      rr_ptr_q  <= rr_ptr_d;
      idx_q     <= idx_d;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign m_valid = m_valid_q;
  assign m_addr  = m_addr_q;
  assign m_data  = m_data_q;
  assign busy    = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: a per-cycle vector table for the
// round-robin / wrap / single-requester patterns, plus hand sequences for
// capture, timeout (or its absence) and asynchronous reset mid-transfer.
module tb_bus_rr_arbiter;

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned D_WIDTH = 32;
  localparam int unsigned A_WIDTH = 8;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [N_REQ-1:0]         req;
  logic [N_REQ*A_WIDTH-1:0] req_addr;
  logic [N_REQ*D_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]         grant;
  logic [N_REQ-1:0]         done;
  logic                     m_valid;
  logic [A_WIDTH-1:0]       m_addr;
  logic [D_WIDTH-1:0]       m_data;
  logic                     m_ready;
  logic                     busy;
  logic                     timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  bus_rr_arbiter #(
    .N_REQ(N_REQ), .D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .grant(grant), .done(done), .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data),
    .m_ready(m_ready), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] grant;
    logic [3:0] done;
    logic       valid;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] r, input logic y, input logic [3:0] g,
                     input logic [3:0] d, input logic v, input logic b);
    vec_t e;
    e.req = r; e.rdy = y; e.grant = g; e.done = d; e.valid = v; e.busy = b;
    vecs.push_back(e);
  endtask

  initial begin
    logic [A_WIDTH-1:0] exp_addr;
    logic [D_WIDTH-1:0] exp_data;

    // Round robin, all requesting, ready always high.
    add(4'hF, 1, 4'b0001, 4'b0000, 1, 1);
    add(4'hF, 1, 4'b0000, 4'b0001, 0, 0);
    add(4'hF, 1, 4'b0010, 4'b0000, 1, 1);
    add(4'hF, 1, 4'b0000, 4'b0010, 0, 0);
    add(4'hF, 1, 4'b0100, 4'b0000, 1, 1);
    add(4'hF, 1, 4'b0000, 4'b0100, 0, 0);
    add(4'hF, 1, 4'b1000, 4'b0000, 1, 1);
    add(4'hF, 1, 4'b0000, 4'b1000, 0, 0);
    add(4'hF, 1, 4'b0001, 4'b0000, 1, 1);
    add(4'hF, 1, 4'b0000, 4'b0001, 0, 0);
    // Single requester with immediate ready: re-granted every 2 cycles.
    add(4'h1, 1, 4'b0001, 4'b0000, 1, 1);
    add(4'h1, 1, 4'b0000, 4'b0001, 0, 0);
    add(4'h1, 1, 4'b0001, 4'b0000, 1, 1);
    add(4'h1, 1, 4'b0000, 4'b0001, 0, 0);
    // Grant to 3, then wrap/skip with req=0101.
    add(4'h8, 0, 4'b1000, 4'b0000, 1, 1);
    add(4'h5, 1, 4'b0000, 4'b1000, 0, 0);
    add(4'h5, 1, 4'b0001, 4'b0000, 1, 1);
    add(4'h5, 1, 4'b0000, 4'b0001, 0, 0);
    add(4'h5, 1, 4'b0100, 4'b0000, 1, 1);
    add(4'h5, 1, 4'b0000, 4'b0100, 0, 0);
    add(4'h0, 0, 4'b0000, 4'b0000, 0, 0);

    req      = '0;
    m_ready  = 1'b0;
    req_addr = {8'h13, 8'h12, 8'h11, 8'h10};
    req_data = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    rst_n    = 1'b0;
    #1;
    chk("reset_grant", 64'(grant), 64'h0);
    chk("reset_valid", 64'(m_valid), 64'h0);
    chk("reset_busy",  64'(busy), 64'h0);
    chk("reset_done",  64'(done), 64'h0);
    chk("reset_terr",  64'(timeout_err), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven cycles: inputs applied, one edge, outputs compared.
    foreach (vecs[i]) begin
      req     = vecs[i].req;
      m_ready = vecs[i].rdy;
      tick();
      chk($sformatf("v%0d_grant", i), 64'(grant),   64'(vecs[i].grant));
      chk($sformatf("v%0d_done", i),  64'(done),    64'(vecs[i].done));
      chk($sformatf("v%0d_valid", i), 64'(m_valid), 64'(vecs[i].valid));
      chk($sformatf("v%0d_busy", i),  64'(busy),    64'(vecs[i].busy));
      chk($sformatf("v%0d_terr", i),  64'(timeout_err), 64'h0);
      if (vecs[i].valid) begin
        exp_addr = 8'h10;
        exp_data = 32'hA000_0000;
        for (int b = 0; b < 4; b++) begin
          if (vecs[i].grant[b]) begin
            exp_addr = 8'h10 + 8'(b);
            exp_data = 32'hA000_0000 + 32'(b);
          end
        end
        chk($sformatf("v%0d_addr", i), 64'(m_addr), 64'(exp_addr));
        chk($sformatf("v%0d_data", i), 64'(m_data), 64'(exp_data));
      end
    end

    // Capture: payload changes and req drop during XFER have no effect.
    req_addr[23:16] = 8'h3C;
    req_data[95:64] = 32'hDEAD_BEEF;
    req     = 4'b0100;
    m_ready = 1'b0;
    tick();
    chk("cap_grant", 64'(grant),  64'h4);
    chk("cap_addr",  64'(m_addr), 64'h3C);
    chk("cap_data",  64'(m_data), 64'hDEAD_BEEF);
    req_data = '0;
    req_addr = '0;
    req      = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("cap_hold%0d_data", c),  64'(m_data),  64'hDEAD_BEEF);
      chk($sformatf("cap_hold%0d_addr", c),  64'(m_addr),  64'h3C);
      chk($sformatf("cap_hold%0d_valid", c), 64'(m_valid), 64'h1);
      chk($sformatf("cap_hold%0d_done", c),  64'(done),    64'h0);
    end
    m_ready = 1'b1;
    tick();
    chk("cap_done",  64'(done),    64'h4);
    chk("cap_valid", 64'(m_valid), 64'h0);
    m_ready = 1'b0;
    tick();
    chk("cap_done_once", 64'(done), 64'h0);

    // Stalled target: abort after TIMEOUT, or wait indefinitely without the feature.
    req     = 4'b0110;
    m_ready = 1'b0;
    tick();
    chk("to_grant", 64'(grant), 64'h2);
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= 15; c++) begin
      tick();
      chk($sformatf("to_wait%0d_valid", c), 64'(m_valid), 64'h1);
      chk($sformatf("to_wait%0d_terr", c),  64'(timeout_err), 64'h0);
    end
    tick();
    chk("to_abort_valid", 64'(m_valid),     64'h0);
    chk("to_abort_grant", 64'(grant),       64'h0);
    chk("to_abort_busy",  64'(busy),        64'h0);
    chk("to_abort_terr",  64'(timeout_err), 64'h1);
    chk("to_abort_done",  64'(done),        64'h0);
    tick();
    chk("to_next_grant", 64'(grant),       64'h4);
    chk("to_next_terr",  64'(timeout_err), 64'h0);
    req     = 4'b0000;
    m_ready = 1'b1;
    tick();
    chk("to_next_done", 64'(done), 64'h4);
`else
    for (int c = 1; c <= 100; c++) begin
      tick();
      chk($sformatf("nto_wait%0d_valid", c), 64'(m_valid), 64'h1);
      chk($sformatf("nto_wait%0d_terr", c),  64'(timeout_err), 64'h0);
    end
    req     = 4'b0000;
    m_ready = 1'b1;
    tick();
    chk("nto_done", 64'(done), 64'h2);
`endif
    m_ready = 1'b0;
    tick();

    // Asynchronous reset in the middle of a transfer.
    req = 4'b0001;
    tick();
    chk("rst_pre_grant", 64'(grant), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_grant", 64'(grant),   64'h0);
    chk("rst_valid", 64'(m_valid), 64'h0);
    chk("rst_done",  64'(done),    64'h0);
    chk("rst_busy",  64'(busy),    64'h0);
    #2;
    rst_n = 1'b1;
    req   = 4'b0100;
    tick();
    chk("rst_post_done",  64'(done),  64'h0);
    chk("rst_post_grant", 64'(grant), 64'h4);
    req     = 4'b0000;
    m_ready = 1'b1;
    tick();
    chk("rst_post_xfer_done", 64'(done), 64'h4);
    m_ready = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
